spike_dispatcher: RTL and testbench
===================================

SPIKE_DISPATCHER -- requirements
Module: spike_dispatcher

Interface
REQ-001 Parameter NUM_AXONS, default 256, meaning number of axon spike lines per timestep.
REQ-002 Parameter AXON_IND_W, default 8, meaning width of axon index (log2 NUM_AXONS).
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 spike_valid_i  input  1  spike vector for one timestep is offered.
REQ-006 spike_vec_i  input  NUM_AXONS  bit k set = axon k spiked this timestep.
REQ-007 spike_ready_o  output  1  block can accept a vector this cycle.
REQ-008 send_spike_o  output  1  axon_ind_o carries a valid spiking axon index.
REQ-009 axon_ind_o  output  AXON_IND_W  index of the axon being dispatched.
REQ-010 ready_i  input  1  downstream weight/neuron stage consumes the current spike.
REQ-011 busy_o  output  1  a timestep is being dispatched.
REQ-012 done_o  output  1  one-cycle pulse: timestep fully dispatched.
REQ-013 spike_cnt_o  output  AXON_IND_W+1  number of spikes dispatched in the last completed timestep.

Function
REQ-014 FSM states SHALL be IDLE, SCAN, DONE.
REQ-015 spike_ready_o SHALL equal (state == IDLE).
REQ-016 In IDLE, spike_valid_i high SHALL latch spike_vec_i into vec_q, clear the spike counter and move to SCAN at that edge.
REQ-017 In SCAN, send_spike_o SHALL equal OR-reduction of vec_q (combinational from registered state).
REQ-018 axon_ind_o SHALL be the lowest set bit index of vec_q while send_spike_o is high, else 0.
REQ-019 An edge with send_spike_o && ready_i SHALL clear that bit of vec_q and increment the counter by 1.
REQ-020 send_spike_o high with ready_i low SHALL hold vec_q, axon_ind_o and send_spike_o unchanged (no drop, no skip).
REQ-021 In SCAN with vec_q == 0, the FSM SHALL move to DONE at the next edge.
REQ-022 In DONE, done_o SHALL be high for exactly one cycle; the FSM then returns to IDLE.
REQ-023 spike_cnt_o SHALL hold its value from the last DONE until the next acceptance, when it clears to 0.
REQ-024 First spike SHALL appear on send_spike_o the cycle after the acceptance edge; with ready_i held high, throughput SHALL be one spike per cycle.
REQ-025 Empty vector SHALL take exactly one SCAN cycle (no spike) then one DONE cycle, with spike_cnt_o = 0.
REQ-026 A full vector SHALL give spike_cnt_o = NUM_AXONS, with no counter wrap (width AXON_IND_W+1).
REQ-027 busy_o SHALL be high in SCAN and DONE.
REQ-028 spike_valid_i outside IDLE SHALL be ignored.

Reset
REQ-029 rst_i high at an edge SHALL force state IDLE, vec_q 0 and counter 0.
REQ-030 After reset: spike_ready_o 1, send_spike_o 0, axon_ind_o 0, busy_o 0, done_o 0, spike_cnt_o 0.
REQ-031 Reset during SCAN SHALL abandon the timestep with no done_o pulse.

Structure
REQ-032 NUM_AXONS, AXON_IND_W and the FSM state encoding SHALL live in shared package snn_pkg.
REQ-033 Lowest-set-bit search SHALL be a separate combinational sub-module spike_pri_enc (vector in, index and any-set out).

Verification
REQ-034 Vector with bits {3,17,200}, ready_i=1 -> axon_ind_o 3, 17, 200 on three consecutive cycles, then done_o with spike_cnt_o=3.
REQ-035 All-zero vector -> no send_spike_o; done_o two cycles after acceptance; spike_cnt_o=0.
REQ-036 All-ones vector, ready_i=1 -> indices 0..255 in order, done_o with spike_cnt_o=256, 258 cycles from acceptance to return to IDLE.
REQ-037 Bits {5,9}, ready_i low for 4 cycles while index 5 is shown -> index 5 held for 4 cycles, then 5 and 9 each dispatched exactly once.
REQ-038 spike_valid_i pulsed mid-SCAN with a different vector -> ignored; original indices only.
REQ-039 rst_i asserted after the 2nd of 10 spikes -> next cycle all outputs at reset values; no done_o; new vector is accepted normally.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared sizing and FSM encoding for the spike dispatch path.
package snn_pkg;

  localparam int NUM_AXONS  = 256;
  localparam int AXON_IND_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/spike_pri_enc.sv
// Lowest-set-bit finder over one timestep's axon spike vector.
module spike_pri_enc #(
  parameter int N = 256,
  parameter int W = 8
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  // Walk downward so the lowest set bit is the last to win.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/spike_dispatcher.sv
// Serialises a timestep's spike vector into one axon index per handshake.
module spike_dispatcher #(
  parameter int NUM_AXONS  = snn_pkg::NUM_AXONS,
  parameter int AXON_IND_W = snn_pkg::AXON_IND_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  spike_valid_i,
  input  logic [NUM_AXONS-1:0]  spike_vec_i,
  output logic                  spike_ready_o,
  output logic                  send_spike_o,
  output logic [AXON_IND_W-1:0] axon_ind_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [AXON_IND_W:0]   spike_cnt_o
);

  import snn_pkg::*;

  logic [1:0]            state_q, state_d;
  logic [NUM_AXONS-1:0]  vec_q, vec_d;
  logic [AXON_IND_W:0]   cnt_q, cnt_d;
  logic [AXON_IND_W-1:0] low_idx;
  logic                  any_set;
  logic                  is_idle;
  logic                  is_scan;
  logic                  is_done;

  spike_pri_enc #(
    .N (NUM_AXONS),
    .W (AXON_IND_W)
  ) u_enc (
    .vec (vec_q),
    .idx (low_idx),
    .any (any_set)
  );

  assign is_idle = (state_q == ST_IDLE);
  assign is_scan = (state_q == ST_SCAN);
  assign is_done = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      is_idle: begin
        if (spike_valid_i) begin
          vec_d   = spike_vec_i;
          cnt_d   = '0;
          state_d = ST_SCAN;
        end
      end
      is_scan: begin
        if (!any_set) begin
          state_d = ST_DONE;
        end else if (ready_i) begin
          // v & (v-1) drops exactly the lowest set bit
          vec_d = vec_q & (vec_q - NUM_AXONS'(1));
          cnt_d = cnt_q + (AXON_IND_W + 1)'(1);
        end
      end
      is_done: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
    end
  end

  assign spike_ready_o = is_idle;
  assign send_spike_o  = is_scan & any_set;
  assign axon_ind_o    = send_spike_o ? low_idx : '0;
  assign busy_o        = is_scan | is_done;
  assign done_o        = is_done;
  assign spike_cnt_o   = cnt_q;

endmodule

// File: tb/tb_spike_dispatcher.sv
// Scoreboarded random and directed bench for spike_dispatcher.
module tb_spike_dispatcher;

  localparam int N = 256;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         spike_valid_i = 1'b0;
  logic [N-1:0] spike_vec_i = '0;
  logic         ready_i = 1'b1;
  logic         spike_ready_o;
  logic         send_spike_o;
  logic [W-1:0] axon_ind_o;
  logic         busy_o;
  logic         done_o;
  logic [W:0]   spike_cnt_o;

  always #5 clk = ~clk;

  spike_dispatcher #(
    .NUM_AXONS  (N),
    .AXON_IND_W (W)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .spike_valid_i (spike_valid_i),
    .spike_vec_i   (spike_vec_i),
    .spike_ready_o (spike_ready_o),
    .send_spike_o  (send_spike_o),
    .axon_ind_o    (axon_ind_o),
    .ready_i       (ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .spike_cnt_o   (spike_cnt_o)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int consumed = 0;
  int stalls = 0;
  int last_evt = 0;
  int last_cnt = 0;
  int exp_idx[$];
  int exp_cnt[$];
  bit rand_rdy = 1'b0;
  bit hold_low = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (hold_low) ready_i = 1'b0;
      else if (rand_rdy) ready_i = ($urandom_range(3) != 0);
      else ready_i = 1'b1;
    end
  end

  // Monitor: compare dispatched indices and timestep summaries to the model.
  always @(negedge clk) begin
    if (rst_i) begin
      exp_idx.delete();
      exp_cnt.delete();
      last_cnt = 0;
    end else begin
      if (send_spike_o) begin
        if (exp_idx.size() == 0) begin
          chk("unexp_spike", send_spike_o, 0);
        end else begin
          chk("axon_ind", axon_ind_o, exp_idx[0]);
          if (ready_i) begin
            void'(exp_idx.pop_front());
            consumed++;
            last_evt = cyc + 1;
          end else begin
            stalls++;
          end
        end
      end
      if (done_o) begin
        if (exp_cnt.size() == 0) begin
          chk("unexp_done", done_o, 0);
        end else begin
          last_cnt = exp_cnt.pop_front();
          chk("left_at_done", exp_idx.size(), 0);
          chk("spike_cnt", spike_cnt_o, last_cnt);
          chk("done_time", cyc, last_evt + 1);
        end
      end
      if (spike_ready_o) chk("cnt_hold", spike_cnt_o, last_cnt);
      chk("busy", busy_o, !spike_ready_o);
    end
  end

  task automatic send_vec(input logic [N-1:0] v, output int acc);
    for (int t = 0; t < 3000 && !spike_ready_o; t++) begin
      @(posedge clk);
      #1;
    end
    chk("accept_wait", spike_ready_o, 1);
    spike_valid_i = 1'b1;
    spike_vec_i = v;
    acc = cyc + 1;
    for (int k = 0; k < N; k++) if (v[k]) exp_idx.push_back(k);
    exp_cnt.push_back($countones(v));
    last_evt = acc;
    @(posedge clk);
    #1;
    spike_valid_i = 1'b0;
    spike_vec_i = '0;
  endtask

  task automatic wait_idle(output int e);
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk);
      #1;
      if (spike_ready_o) break;
    end
    chk("idle_wait", spike_ready_o, 1);
    e = cyc;
  endtask

  task automatic run_vec(input logic [N-1:0] v, input bit chk_lat);
    int a;
    int e;
    send_vec(v, a);
    wait_idle(e);
    if (chk_lat) chk("latency", e - a, $countones(v) + 2);
  endtask

  function automatic logic [N-1:0] rvec(input int dens);
    logic [N-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k] = ($urandom_range(99) < dens);
    return v;
  endfunction

  initial begin
    logic [N-1:0] v;
    int a;
    int e;
    int base;

    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    chk("rst_ready", spike_ready_o, 1);
    chk("rst_send", send_spike_o, 0);
    chk("rst_ind", axon_ind_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_cnt", spike_cnt_o, 0);

    v = '0;
    v[3] = 1'b1;
    v[17] = 1'b1;
    v[200] = 1'b1;
    run_vec(v, 1'b1);

    run_vec('0, 1'b1);

    run_vec('1, 1'b1);

    v = '0;
    v[5] = 1'b1;
    v[9] = 1'b1;
    base = stalls;
    hold_low = 1'b1;
    send_vec(v, a);
    repeat (4) @(posedge clk);
    hold_low = 1'b0;
    wait_idle(e);
    chk("stall_cycles", stalls - base, 4);

    v = '0;
    for (int k = 0; k < 8; k++) v[k * 30 + 1] = 1'b1;
    send_vec(v, a);
    @(posedge clk);
    #1;
    spike_valid_i = 1'b1;
    spike_vec_i = ~v;
    @(posedge clk);
    #1;
    spike_valid_i = 1'b0;
    spike_vec_i = '0;
    wait_idle(e);
    chk("ignore_lat", e - a, 10);

    v = '0;
    for (int k = 0; k < 10; k++) v[k * 10 + 7] = 1'b1;
    base = consumed;
    send_vec(v, a);
    for (int t = 0; t < 100 && consumed < base + 2; t++) @(posedge clk);
    chk("pre_rst_spikes", consumed - base, 2);
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    chk("mid_rst_ready", spike_ready_o, 1);
    chk("mid_rst_send", send_spike_o, 0);
    chk("mid_rst_ind", axon_ind_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_done", done_o, 0);
    chk("mid_rst_cnt", spike_cnt_o, 0);
    v = '0;
    v[0] = 1'b1;
    v[255] = 1'b1;
    run_vec(v, 1'b1);

    for (int r = 0; r < 20; r++) begin
      rand_rdy = r[0];
      run_vec(rvec($urandom_range(40)), !r[0]);
    end
    rand_rdy = 1'b0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
